// File: rtl/seq_mul_param.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode and busy/done handshake.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: leave ITER as soon as the remaining multiplier bits are all zero.
module seq_mul_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 last_iter;

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exactly right as unsigned.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;
    end

    always_comb begin
        last_iter = (cnt == CNT_W'(WIDTH-1));
`ifdef SEQ_MUL_EARLY_EXIT_EN
        last_iter = last_iter | (mplier[WIDTH-1:1] == '0);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (last_iter) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        done   <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                ITER: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    result <= neg ? ('0 - acc) : acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
